ysyx_23060203_icache: RTL

- Direct-mapped, read-only instruction cache between IFU fetch port and the MemArb IFU read port.
- Serves IFU fetch requests over a valid/ready handshake; hits return the next cycle.
- On a miss, refills one line with a single AXI INCR burst.
- Supports fence.i whole-cache invalidation and pipeline flush (discards the pending response).

---
 rtl/ysyx_23060203_icache_pkg.sv | 32 +++
 rtl/ysyx_23060203_icache_array.sv | 66 ++++++
 rtl/ysyx_23060203_icache.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060203_icache_pkg.sv
// rtl/ysyx_23060203_icache_pkg.sv - shared types, AXI constants and address helpers for the icache
// Contents: state_e (controller states), BURST_INCR / SIZE_WORD AXI encodings,
//           get_offset / get_index / get_tag address field extractors.
package ysyx_23060203_icache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MISS_AR = 3'd2,
        MISS_R  = 3'd3,
        RESP    = 3'd4
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    // Word offset inside the line; callers slice the low bits they need.
    function automatic logic [31:0] get_offset(input logic [31:0] addr, input int off_bits);
        return (addr & ((32'd1 << off_bits) - 32'd1)) >> 2;
    endfunction

    function automatic logic [31:0] get_index(input logic [31:0] addr, input int off_bits,
                                              input int idx_bits);
        return (addr >> off_bits) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] get_tag(input logic [31:0] addr, input int off_bits,
                                            input int idx_bits);
        return addr >> (off_bits + idx_bits);
    endfunction

endpackage

// File: rtl/ysyx_23060203_icache_array.sv
// rtl/ysyx_23060203_icache_array.sv - tag/valid/data storage with one write port and one read port
// Ports: clock, reset (async, clears valid bits only)
//        inval                    - clear every valid bit
//        wr_set/wr_word/wr_data   - data_we writes one word and drops the line's valid bit
//        tag_we/tag_wdata/tag_valid - write the line tag and its valid bit
//        rd_set/rd_word           - combinational read of valid, tag and one data word
module ysyx_23060203_icache_array #(
    parameter int NSETS  = 16,
    parameter int BEATS  = 4,
    parameter int IDX_W  = 4,
    parameter int WOFF_W = 2,
    parameter int TAG_W  = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inval,
    input  logic [IDX_W-1:0]  wr_set,
    input  logic              data_we,
    input  logic [WOFF_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  tag_wdata,
    input  logic              tag_valid,
    input  logic [IDX_W-1:0]  rd_set,
    input  logic [WOFF_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data
);

    logic [31:0]      data_q  [NSETS][BEATS];
    logic [TAG_W-1:0] tag_q   [NSETS];
    logic [NSETS-1:0] valid_q;

    always_ff @(posedge clock) begin
        if (data_we) begin
            data_q[wr_set][wr_word] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_set] <= tag_wdata;
        end
    end

    // A line being refilled is invalid until its final beat, so a failed or
    // invalidated refill never leaves partially overwritten data marked valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (inval) begin
                valid_q <= '0;
            end
            if (data_we) begin
                valid_q[wr_set] <= 1'b0;
            end
            if (tag_we) begin
                valid_q[wr_set] <= tag_valid;
            end
        end
    end

    assign rd_valid = valid_q[rd_set];
    assign rd_tag   = tag_q[rd_set];
    assign rd_data  = data_q[rd_set][rd_word];

endmodule

// File: rtl/ysyx_23060203_icache.sv
// rtl/ysyx_23060203_icache.sv - direct-mapped read-only instruction cache with AXI burst refill
// Ports: req_*  - IFU fetch request (valid/ready, PC)
//        resp_* - instruction response (valid/ready, word, refill error)
//        flush  - drop the outstanding request/response
//        invalidate - fence.i, clear all lines
//        ar*/r* - AXI read address / read data channels for line refill
module ysyx_23060203_icache
    import ysyx_23060203_icache_pkg::*;
#(
    parameter int NSETS      = 16,
    parameter int LINE_BYTES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        flush,
    input  logic        invalidate,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);

    localparam int BEATS    = LINE_BYTES / 4;
    localparam int OFF_BITS = $clog2(LINE_BYTES);
    localparam int WOFF_W   = (OFF_BITS > 2) ? OFF_BITS - 2 : 1;
    localparam int IDX_W    = $clog2(NSETS);
    localparam int TAG_W    = 32 - OFF_BITS - IDX_W;
    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(BEATS - 1);

    state_e            state_q;
    logic [31:0]       addr_q;
    logic [WOFF_W-1:0] cnt_q;
    logic              err_q;
    logic              cancel_q;
    logic              inval_pend_q;
    logic [31:0]       inst_q;
    logic              resp_err_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              resp_valid_q;
    logic              req_ready_q;

    logic [31:0]       off_full, idx_full, tag_full;
    logic [WOFF_W-1:0] word_off;
    logic [IDX_W-1:0]  set_idx;
    logic [TAG_W-1:0]  line_tag;
    logic              arr_rd_valid;
    logic [TAG_W-1:0]  arr_rd_tag;
    logic [31:0]       arr_rd_data;
    logic              hit;
    logic              beat;
    logic              beat_last;
    logic              err_now;
    logic              cancel_now;
    logic              inv_now;
    logic              arr_inval;
    logic              unused_bits;

    assign off_full = get_offset(addr_q, OFF_BITS);
    assign idx_full = get_index(addr_q, OFF_BITS, IDX_W);
    assign tag_full = get_tag(addr_q, OFF_BITS, IDX_W);
    assign word_off = off_full[WOFF_W-1:0];
    assign set_idx  = idx_full[IDX_W-1:0];
    assign line_tag = tag_full[TAG_W-1:0];
    assign unused_bits = ^{off_full[31:WOFF_W], idx_full[31:IDX_W], tag_full[31:TAG_W], rresp[0]};

    assign hit       = (state_q == LOOKUP) && arr_rd_valid && (arr_rd_tag == line_tag);
    assign beat      = (state_q == MISS_R) && rvalid && rready_q;
    assign beat_last = beat && (rlast || (cnt_q == LAST_BEAT));

    // Sticky flags folded with this cycle's inputs so the final beat sees them.
    assign err_now    = err_q | rresp[1];
    assign cancel_now = cancel_q | flush;
    assign inv_now    = inval_pend_q | invalidate;

    // Outside a refill fence.i acts at once; during a refill it is deferred to
    // the final beat so the line being filled is also left invalid.
    assign arr_inval = (invalidate && (state_q == IDLE || state_q == LOOKUP || state_q == RESP))
                     || (beat_last && inv_now);

    ysyx_23060203_icache_array #(
        .NSETS  (NSETS),
        .BEATS  (BEATS),
        .IDX_W  (IDX_W),
        .WOFF_W (WOFF_W),
        .TAG_W  (TAG_W)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .inval     (arr_inval),
        .wr_set    (set_idx),
        .data_we   (beat),
        .wr_word   (cnt_q),
        .wr_data   (rdata),
        .tag_we    (beat_last),
        .tag_wdata (line_tag),
        .tag_valid (!err_now && !inv_now),
        .rd_set    (set_idx),
        .rd_word   (word_off),
        .rd_valid  (arr_rd_valid),
        .rd_tag    (arr_rd_tag),
        .rd_data   (arr_rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            cancel_q     <= 1'b0;
            inval_pend_q <= 1'b0;
            inst_q       <= '0;
            resp_err_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        req_ready_q <= 1'b0;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (flush) begin
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (hit) begin
                        inst_q       <= arr_rd_data;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q        <= '0;
                        err_q        <= 1'b0;
                        cancel_q     <= 1'b0;
                        inval_pend_q <= 1'b0;
                        arvalid_q    <= 1'b1;
                        state_q      <= MISS_AR;
                    end
                end
                MISS_AR: begin
                    if (flush) cancel_q <= 1'b1;
                    if (invalidate) inval_pend_q <= 1'b1;
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= MISS_R;
                    end
                end
                MISS_R: begin
                    if (flush) cancel_q <= 1'b1;
                    if (invalidate) inval_pend_q <= 1'b1;
                    if (beat) begin
                        cnt_q <= cnt_q + WOFF_W'(1);
                        if (rresp[1]) err_q <= 1'b1;
                        if (cnt_q == word_off) inst_q <= rdata;
                        if (beat_last) begin
                            rready_q <= 1'b0;
                            if (cancel_now) begin
                                req_ready_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                resp_valid_q <= 1'b1;
                                resp_err_q   <= err_now;
                                state_q      <= RESP;
                            end
                        end
                    end
                end
                RESP: begin
                    if (flush || resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_inst  = inst_q;
    assign resp_err   = resp_err_q;
    assign arvalid    = arvalid_q;
    assign araddr     = {addr_q[31:OFF_BITS], {OFF_BITS{1'b0}}};
    assign arlen      = 8'(BEATS - 1);
    assign arsize     = SIZE_WORD;
    assign arburst    = BURST_INCR;
    assign rready     = rready_q;

endmodule
